store_unit: RTL and testbench

STORE_UNIT -- requirements
Module: store_unit

---
 rtl/store_unit.sv | 160 ++++++++++++++++
 tb/tb_store_unit.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/store_unit.sv
// Store unit: lane-aligns SB/SH/SW stores into a word-wide memory write request.
// Latency: done 2 + mem_ready wait cycles after start; done 1 cycle after start on error.
// Backpressure: holds mem_valid with stable addr/data/strb until mem_ready or TIMEOUT waits.
module store_unit #(
  parameter int TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  STOREop,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  localparam logic [1:0] OP_SB = 2'd0;
  localparam logic [1:0] OP_SH = 2'd1;
  localparam logic [1:0] OP_SW = 2'd2;

  localparam logic [1:0] ERR_OK      = 2'd0;
  localparam logic [1:0] ERR_MISALIGN = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;
  localparam logic [1:0] ERR_ILLEGAL = 2'd3;

  // Counter value at which one more unanswered REQ cycle makes it reach TIMEOUT.
  localparam logic [7:0] LP_LAST_WAIT = 8'(TIMEOUT - 1);

  state_t      r_state;
  logic        r_mem_valid;
  logic [31:0] r_mem_addr;
  logic [31:0] r_mem_wdata;
  logic [3:0]  r_mem_wstrb;
  logic        r_busy;
  logic        r_done;
  logic [1:0]  r_err;
  logic [7:0]  r_wait_cnt;

  logic        w_illegal;
  logic        w_misalign;
  logic [3:0]  w_strb;
  logic [31:0] w_lane_data;

  // Decode the incoming request: legality, alignment, lane strobes and replicated data.
  always_comb begin
    w_illegal   = 1'b0;
    w_misalign  = 1'b0;
    w_strb      = 4'b0000;
    w_lane_data = 32'd0;
    case (STOREop)
      OP_SB: begin
        w_strb      = 4'b0001 << addr[1:0];
        w_lane_data = {4{wdata[7:0]}};
      end
      OP_SH: begin
        w_misalign  = addr[0];
        w_strb      = 4'b0011 << addr[1:0];
        w_lane_data = {2{wdata[15:0]}};
      end
      OP_SW: begin
        w_misalign  = (addr[1:0] != 2'b00);
        w_strb      = 4'b1111;
        w_lane_data = wdata;
      end
      default: begin
        w_illegal = 1'b1;
      end
    endcase
  end

  // Control FSM with all outputs registered; FIN accepts a new start to allow 2-cycle back-to-back stores.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= S_IDLE;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
      r_mem_wstrb <= 4'b0000;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= ERR_OK;
      r_wait_cnt  <= 8'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE, S_FIN: begin
          if (start) begin
            r_busy <= 1'b1;
            if (w_illegal) begin
              // Illegal op wins over alignment; straight to FIN, no bus activity.
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= ERR_ILLEGAL;
            end else if (w_misalign) begin
              r_state <= S_FIN;
              r_done  <= 1'b1;
              r_err   <= ERR_MISALIGN;
            end else begin
              r_state     <= S_REQ;
              r_mem_valid <= 1'b1;
              r_mem_addr  <= {addr[31:2], 2'b00};
              r_mem_wdata <= w_lane_data;
              r_mem_wstrb <= w_strb;
              r_wait_cnt  <= 8'd0;
            end
          end else begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
          end
        end
        S_REQ: begin
          if (mem_ready) begin
            // Acceptance takes priority even on the cycle the wait limit is hit.
            r_state     <= S_FIN;
            r_done      <= 1'b1;
            r_err       <= ERR_OK;
            r_mem_valid <= 1'b0;
            r_mem_wstrb <= 4'b0000;
          end else begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
            if (r_wait_cnt == LP_LAST_WAIT) begin
              r_state     <= S_FIN;
              r_done      <= 1'b1;
              r_err       <= ERR_TIMEOUT;
              r_mem_valid <= 1'b0;
              r_mem_wstrb <= 4'b0000;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_busy      <= 1'b0;
          r_mem_valid <= 1'b0;
          r_mem_wstrb <= 4'b0000;
        end
      endcase
    end
  end

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_wstrb = r_mem_wstrb;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_store_unit.sv
// Directed bench for store_unit built with TIMEOUT=4.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
// Expected values are hand-computed constants.
module tb_store_unit;

  logic        clk;
  logic        resetn;
  logic        start;
  logic [1:0]  STOREop;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        busy;
  logic        done;
  logic [1:0]  err;

  int n_chk;
  int n_pass;

  store_unit #(.TIMEOUT(4)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .STOREop   (STOREop),
    .addr      (addr),
    .wdata     (wdata),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_wstrb (mem_wstrb),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d);
    STOREop = op;
    addr    = a;
    wdata   = d;
    start   = 1'b1;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    resetn = 1'b0; start = 1'b0; STOREop = 2'd0; addr = 32'd0; wdata = 32'd0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_valid", 32'(mem_valid), 32'd0);
    chk("rst_wstrb", 32'(mem_wstrb), 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_wdata", mem_wdata, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    resetn = 1'b1;
    tick();

    // SB to lane 3, memory ready immediately.
    mem_ready = 1'b1;
    req(2'd0, 32'h0000_1003, 32'hAABB_CCDD);
    tick(); start = 1'b0;
    chk("sb_valid", 32'(mem_valid), 32'd1);
    chk("sb_addr", mem_addr, 32'h0000_1000);
    chk("sb_wstrb", 32'(mem_wstrb), 32'h8);
    chk("sb_wdata", mem_wdata, 32'hDDDD_DDDD);
    chk("sb_busy", 32'(busy), 32'd1);
    chk("sb_nodone_c1", 32'(done), 32'd0);
    tick();
    chk("sb_done_c2", 32'(done), 32'd1);
    chk("sb_err", 32'(err), 32'd0);
    chk("sb_valid_drop", 32'(mem_valid), 32'd0);
    chk("sb_wstrb_drop", 32'(mem_wstrb), 32'd0);
    tick();
    chk("sb_done_once", 32'(done), 32'd0);
    chk("sb_idle", 32'(busy), 32'd0);

    // SB to lane 1.
    req(2'd0, 32'h0000_0001, 32'h0000_0077);
    tick(); start = 1'b0;
    chk("sb1_wstrb", 32'(mem_wstrb), 32'h2);
    chk("sb1_wdata", mem_wdata, 32'h7777_7777);
    tick(); tick();

    // SH to upper half, memory stalls for 3 cycles.
    mem_ready = 1'b0;
    req(2'd1, 32'h0000_2002, 32'h0000_1234);
    tick(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("sh_valid_c%0d", i), 32'(mem_valid), 32'd1);
      chk($sformatf("sh_wstrb_c%0d", i), 32'(mem_wstrb), 32'hC);
      chk($sformatf("sh_wdata_c%0d", i), mem_wdata, 32'h1234_1234);
      chk($sformatf("sh_addr_c%0d", i), mem_addr, 32'h0000_2000);
      chk($sformatf("sh_nodone_c%0d", i), 32'(done), 32'd0);
      if (i == 4) mem_ready = 1'b1;
      tick();
    end
    chk("sh_done_c5", 32'(done), 32'd1);
    chk("sh_err", 32'(err), 32'd0);
    mem_ready = 1'b0;
    tick();

    // Misaligned SW, then illegal op.
    req(2'd2, 32'h0000_3001, 32'h1111_2222);
    tick(); start = 1'b0;
    chk("mis_done_c1", 32'(done), 32'd1);
    chk("mis_err", 32'(err), 32'd1);
    chk("mis_novalid", 32'(mem_valid), 32'd0);
    tick();
    chk("mis_done_once", 32'(done), 32'd0);
    chk("mis_err_hold", 32'(err), 32'd1);
    chk("mis_idle", 32'(busy), 32'd0);
    req(2'd3, 32'h0000_0000, 32'h0);
    tick(); start = 1'b0;
    chk("ill_done_c1", 32'(done), 32'd1);
    chk("ill_err", 32'(err), 32'd3);
    chk("ill_novalid", 32'(mem_valid), 32'd0);
    tick();

    // Timeout: no mem_ready ever.
    req(2'd2, 32'h0000_0040, 32'h0000_0055);
    tick(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("to_valid_c%0d", i), 32'(mem_valid), 32'd1);
      tick();
    end
    chk("to_done", 32'(done), 32'd1);
    chk("to_err", 32'(err), 32'd2);
    chk("to_valid_drop", 32'(mem_valid), 32'd0);
    tick();

    // mem_ready first raised in the last allowed wait cycle.
    req(2'd2, 32'h0000_0044, 32'h0000_0066);
    tick(); start = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      chk($sformatf("tl_valid_c%0d", i), 32'(mem_valid), 32'd1);
      if (i == 4) mem_ready = 1'b1;
      tick();
    end
    chk("tl_done", 32'(done), 32'd1);
    chk("tl_err", 32'(err), 32'd0);
    mem_ready = 1'b0;
    tick();

    // start pulsed while busy is dropped.
    req(2'd2, 32'h0000_0050, 32'h0000_0001);
    tick();
    addr = 32'h0000_0054;
    tick(); start = 1'b0;
    mem_ready = 1'b1;
    chk("busy_addr_hold", mem_addr, 32'h0000_0050);
    tick();
    chk("busy_done", 32'(done), 32'd1);
    tick();
    chk("busy_no2nd_valid", 32'(mem_valid), 32'd0);
    chk("busy_no2nd_busy", 32'(busy), 32'd0);
    tick();
    chk("busy_no2nd_done", 32'(done), 32'd0);

    // Back-to-back SW stores, done every 2 cycles.
    req(2'd2, 32'h0000_0060, 32'h1111_1111);
    tick();
    chk("b2b_wdata1", mem_wdata, 32'h1111_1111);
    addr = 32'h0000_0064; wdata = 32'h2222_2222;
    tick();
    chk("b2b_done1", 32'(done), 32'd1);
    tick(); start = 1'b0;
    chk("b2b_valid2", 32'(mem_valid), 32'd1);
    chk("b2b_addr2", mem_addr, 32'h0000_0064);
    chk("b2b_wdata2", mem_wdata, 32'h2222_2222);
    chk("b2b_gap", 32'(done), 32'd0);
    tick();
    chk("b2b_done2", 32'(done), 32'd1);
    tick();

    // Reset during REQ, then a normal store.
    mem_ready = 1'b0;
    req(2'd2, 32'h0000_0070, 32'h0BAD_0BAD);
    tick(); start = 1'b0;
    chk("mr_valid", 32'(mem_valid), 32'd1);
    resetn = 1'b0;
    tick();
    chk("mr_valid_drop", 32'(mem_valid), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_nodone", 32'(done), 32'd0);
    resetn = 1'b1;
    tick();
    chk("mr_nodone_after", 32'(done), 32'd0);
    mem_ready = 1'b1;
    req(2'd2, 32'h0000_0080, 32'hCAFE_F00D);
    tick(); start = 1'b0;
    chk("post_valid", 32'(mem_valid), 32'd1);
    chk("post_wstrb", 32'(mem_wstrb), 32'hF);
    chk("post_wdata", mem_wdata, 32'hCAFE_F00D);
    tick();
    chk("post_done", 32'(done), 32'd1);
    chk("post_err", 32'(err), 32'd0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
